// File: rtl/store_drain.sv
// Store drain stage: writes retired stores from the store buffer head to
// data memory, popping each entry only once the write has completed.
module store_drain #(
   parameter int STORE_GROUP = 8,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        retire_store,
   input  logic        sb_head_valid,
   input  logic [3:0]  sb_head_wstrb,
   input  logic [31:0] sb_head_addr,
   input  logic [31:0] sb_head_data,
   output logic        sb_pop,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   output logic        drain_empty
);

   if (CNT_W < $clog2(STORE_GROUP + 1)) begin : g_cnt_chk
      $error("CNT_W too narrow for STORE_GROUP");
   end

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] pending;
   logic [CNT_W-1:0] pending_nxt;
   logic [31:0]      phys;

   assign sb_pop      = (state == WAIT) && data_data_ok;
   assign pending_nxt = pending + CNT_W'(retire_store) - CNT_W'(sb_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         pending <= pending_nxt;
         unique case (state)
            IDLE: if (pending != '0 && sb_head_valid) state <= REQ;
            REQ:  if (data_addr_ok) state <= WAIT;
            WAIT: if (data_data_ok) state <= (pending_nxt != '0) ? REQ : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign data_req    = (state == REQ);
   assign data_wr     = data_req;
   assign drain_empty = (pending == '0) && (state == IDLE);
   assign data_wstrb  = sb_head_wstrb;
   assign data_wdata  = sb_head_data;

   // kseg0/kseg1 are unmapped windows onto the low 512 MB
   assign phys = (sb_head_addr[31:30] == 2'b10) ?
                 {3'b000, sb_head_addr[28:0]} : sb_head_addr;

   always_comb begin
      data_size = 2'd2;
      data_addr = {phys[31:2], 2'b00};
      case (sb_head_wstrb)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            data_size = 2'd0;
            data_addr = phys;
         end
         4'b0011, 4'b1100: begin
            data_size = 2'd1;
            data_addr = phys;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: store buffer model, memory responder and a
// scoreboard of expected write requests in head order.
module tb_store_drain;

   typedef struct {
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] data;
   } sb_ent_t;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  exp_size;
      logic [31:0] exp_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        retire_store;
   logic        sb_head_valid;
   logic [3:0]  sb_head_wstrb;
   logic [31:0] sb_head_addr;
   logic [31:0] sb_head_data;
   logic        sb_pop;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic        drain_empty;

   store_drain #(.STORE_GROUP(8), .CNT_W(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .retire_store (retire_store),
      .sb_head_valid(sb_head_valid),
      .sb_head_wstrb(sb_head_wstrb),
      .sb_head_addr (sb_head_addr),
      .sb_head_data (sb_head_data),
      .sb_pop       (sb_pop),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .drain_empty  (drain_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sb_ent_t sbq[$];
   exp_t    expq[$];
   int      req_cyc[$];
   int      pop_cyc[$];

   logic hv_en = 1'b1;
   logic auto  = 1'b0;
   logic dok_q = 1'b0;
   logic s_req, s_pop, s_empty, s_acc;
   logic [1:0]  s_size;
   logic [31:0] s_addr;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic upd_head();
      if (sbq.size() > 0) begin
         sb_head_valid = hv_en;
         sb_head_wstrb = sbq[0].wstrb;
         sb_head_addr  = sbq[0].addr;
         sb_head_data  = sbq[0].data;
      end else begin
         sb_head_valid = 1'b0;
         sb_head_wstrb = '0;
         sb_head_addr  = '0;
         sb_head_data  = '0;
      end
   endtask

   task automatic push_store(input vec_t v);
      sb_ent_t e;
      exp_t    x;
      e.wstrb = v.wstrb;
      e.addr  = v.addr;
      e.data  = v.data;
      x.addr  = v.exp_addr;
      x.size  = v.exp_size;
      x.wstrb = v.wstrb;
      x.data  = v.data;
      sbq.push_back(e);
      expq.push_back(x);
      upd_head();
   endtask

   // One clock cycle: inputs applied at posedge+1, outputs sampled at negedge.
   task automatic tick(input logic ret, input logic aok, input logic dok);
      exp_t x;
      retire_store = ret;
      if (auto) begin
         data_addr_ok = data_req;
         data_data_ok = dok_q;
      end else begin
         data_addr_ok = aok;
         data_data_ok = dok;
      end
      @(negedge clk);
      s_req   = data_req;
      s_pop   = sb_pop;
      s_empty = drain_empty;
      s_size  = data_size;
      s_addr  = data_addr;
      s_acc   = data_req && data_addr_ok;
      if (data_req) chk("data_wr", {31'b0, data_wr}, 32'd1);
      if (s_acc) begin
         req_cyc.push_back(cyc);
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual=%h required=none", data_addr);
         end else begin
            x = expq.pop_front();
            chk("req_addr", data_addr, x.addr);
            chk("req_size", {30'b0, data_size}, {30'b0, x.size});
            chk("req_wstrb", {28'b0, data_wstrb}, {28'b0, x.wstrb});
            chk("req_wdata", data_wdata, x.data);
         end
      end
      if (s_pop) pop_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (s_pop && sbq.size() > 0) void'(sbq.pop_front());
      upd_head();
      dok_q = s_acc;
      retire_store = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      cyc++;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 40; n++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (s_empty) break;
      end
      chk({name, "_drained"}, {31'b0, s_empty}, 32'd1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{4'b0100, 32'hA000_0002, 32'h1111_1111, 2'd0, 32'h0000_0002};
      vecs[1] = '{4'b1100, 32'h0040_0002, 32'h2222_2222, 2'd1, 32'h0040_0002};
      vecs[2] = '{4'b0111, 32'h8000_0013, 32'h3333_3333, 2'd2, 32'h0000_0010};
      vecs[3] = '{4'b0001, 32'h0000_0003, 32'h4444_4444, 2'd0, 32'h0000_0003};
      vecs[4] = '{4'b1111, 32'hBFC0_0000, 32'h5555_5555, 2'd2, 32'h1FC0_0000};
      vecs[5] = '{4'b0000, 32'h1234_5677, 32'h6666_6666, 2'd2, 32'h1234_5674};
      vecs[6] = '{4'b0011, 32'hC000_0000, 32'h7777_7777, 2'd1, 32'hC000_0000};

      resetn       = 1'b0;
      retire_store = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      upd_head();
      #2;
      chk("rst_req", {31'b0, data_req}, 32'd0);
      chk("rst_pop", {31'b0, sb_pop}, 32'd0);
      chk("rst_empty", {31'b0, drain_empty}, 32'd1);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      // single store with exact cycle timing
      push_store('{4'b1111, 32'h8000_1004, 32'hDEAD_BEEF, 2'd2, 32'h0000_1004});
      for (int t = 0; t <= 6; t++) begin
         tick(t == 0, t == 3, t == 5);
         chk($sformatf("single_req_t%0d", t), {31'b0, s_req},
             {31'b0, (t == 2 || t == 3)});
         chk($sformatf("single_pop_t%0d", t), {31'b0, s_pop},
             {31'b0, (t == 5)});
         chk($sformatf("single_empty_t%0d", t), {31'b0, s_empty},
             {31'b0, (t == 0 || t == 6)});
         if (t == 2) begin
            chk("single_addr", s_addr, 32'h0000_1004);
            chk("single_size", {30'b0, s_size}, 32'd2);
         end
      end

      // size and address mapping table
      auto = 1'b1;
      foreach (vecs[i]) begin
         push_store(vecs[i]);
         tick(1'b1, 1'b0, 1'b0);
         drain($sformatf("vec%0d", i));
      end

      // burst of three retires, immediate addr_ok
      req_cyc.delete();
      pop_cyc.delete();
      for (int i = 0; i < 3; i++)
         push_store('{4'b1111, 32'h0000_0100 + 32'(4 * i),
                      32'hB000_0000 + 32'(i), 2'd2,
                      32'h0000_0100 + 32'(4 * i)});
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
      drain("burst");
      chk("burst_reqs", req_cyc.size(), 32'd3);
      chk("burst_pops", pop_cyc.size(), 32'd3);
      if (req_cyc.size() == 3 && pop_cyc.size() == 3)
         for (int i = 0; i < 2; i++)
            chk($sformatf("burst_gap%0d", i), req_cyc[i + 1], pop_cyc[i] + 1);

      // retire and pop in the same cycle with two pending
      auto = 1'b0;
      pop_cyc.delete();
      for (int i = 0; i < 3; i++)
         push_store('{4'b0011, 32'h0000_0200 + 32'(4 * i),
                      32'hC000_0000 + 32'(i), 2'd1,
                      32'h0000_0200 + 32'(4 * i)});
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      chk("simul_pop", {31'b0, s_pop}, 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      chk("simul_req_next", {31'b0, s_req}, 32'd1);
      chk("simul_busy", {31'b0, s_empty}, 32'd0);
      auto = 1'b1;
      drain("simul");
      chk("simul_pops", pop_cyc.size(), 32'd3);

      // head not valid gates the request
      hv_en = 1'b0;
      push_store('{4'b1000, 32'h0000_0303, 32'hD00D_0003, 2'd0, 32'h0000_0303});
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk($sformatf("gate_hold%0d", i), {31'b0, s_req}, 32'd0);
      end
      hv_en = 1'b1;
      upd_head();
      tick(1'b0, 1'b0, 1'b0);
      chk("gate_rise_same", {31'b0, s_req}, 32'd0);
      tick(1'b0, 1'b0, 1'b0);
      chk("gate_rise_next", {31'b0, s_req}, 32'd1);
      drain("gate");

      // reset while waiting for data_ok
      auto = 1'b0;
      push_store('{4'b1111, 32'h0000_0400, 32'hE000_0004, 2'd2, 32'h0000_0400});
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      data_data_ok = 1'b1;
      #1;
      chk("rstmid_pop_before", {31'b0, sb_pop}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("rstmid_req", {31'b0, data_req}, 32'd0);
      chk("rstmid_pop", {31'b0, sb_pop}, 32'd0);
      chk("rstmid_empty", {31'b0, drain_empty}, 32'd1);
      data_data_ok = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick(1'b0, 1'b0, 1'b1);
      chk("rstmid_late_ok", {31'b0, s_pop}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk($sformatf("rstmid_idle%0d", i), {31'b0, s_req | ~s_empty}, 32'd0);
      end
      sbq.delete();
      upd_head();

      chk("expq_empty", expq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_drain.md
# store_drain

Store drain stage directly downstream of the speculative store buffer. It counts stores retired by the commit stage and, for each retired store, issues one write on the data-memory request/response bus using the buffer head entry. It pops the head only after the memory returns `data_data_ok`, so load forwarding from that entry stays valid until the write is globally visible. One write is outstanding at a time.

## Interface
Parameters:
- `STORE_GROUP`, 8: store buffer depth; bounds the retired-store counter.
- `CNT_W`, 4: width of the retired-store counter; holds 0..`STORE_GROUP`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `retire_store` in 1: one store retired this cycle; at most one per cycle.
- `sb_head_valid` in 1: store buffer head entry valid.
- `sb_head_wstrb` in 4: head byte strobes.
- `sb_head_addr` in 32: head virtual address (`virt_t`).
- `sb_head_data` in 32: head data (`uint32_t`).
- `sb_pop` out 1: pop the head; drives the buffer's commit-store-valid input.
- `data_req` out 1: memory request valid.
- `data_wr` out 1: constant 1 whenever `data_req` is 1.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` out 32: physical address.
- `data_wstrb` out 4: byte strobes.
- `data_wdata` out 32: write data.
- `data_addr_ok` in 1: request accepted this cycle.
- `data_data_ok` in 1: write completed this cycle.
- `drain_empty` out 1: no retired store pending and the FSM is IDLE; used by SYNC/ERET stall logic.

## Operation
- Counter `pending`:
  - +1 on `retire_store`.
  - −1 on `sb_pop`.
  - Both in the same cycle: unchanged.
  - Retire while `pending`=`STORE_GROUP` does not occur by construction and needs no handling.
- FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ when `pending`≠0 and `sb_head_valid`=1.
  - REQ→WAIT on `data_addr_ok`.
  - In WAIT, on `data_data_ok`: go to REQ if (`pending`−1+`retire_store`)≠0, otherwise go to IDLE.
- `data_req`=1 exactly when the state is REQ.
- `data_addr`, `data_wstrb`, `data_wdata` and `data_size` are driven combinationally from the `sb_head_*` inputs in REQ and WAIT. They are stable because the head does not move until the pop.
- `sb_pop` is combinational: it equals `data_data_ok` when the state is WAIT, and is 0 otherwise. A `data_data_ok` outside WAIT is ignored.
- Address mapping:
  - If `sb_head_addr[31:30]`=2'b10 (kseg0/kseg1), then `data_addr`={3'b000, `addr[28:0]`}.
  - Otherwise `data_addr` = `addr` (identity).
- Size from strobe:
  - 0001, 0010, 0100, 1000 → size 0.
  - 0011, 1100 → size 1.
  - Any other nonzero strobe → size 2, with `data_addr[1:0]` forced to 00 (covers SWL/SWR partial-word strobes).
  - An all-zero strobe is still issued as size 2 with strobe 0000.
- `drain_empty` = (`pending`==0) and (state==IDLE).
- No flush input: retired stores are architectural and always drain.

## Timing
- Reset (async assert): state IDLE, `pending`=0. `data_req`=0, `sb_pop`=0, `drain_empty`=1 immediately, without waiting for a clock edge. All other outputs are don't-care while `data_req`=0.
- Reset in mid-transaction abandons any outstanding write. A `data_data_ok` arriving after reset is ignored.
- `retire_store` at cycle t → `pending`=1 at t+1 → `data_req`=1 at t+2 if `sb_head_valid`.
- `data_req` stays high until and including the `data_addr_ok` cycle; it is low the cycle after.
- `data_data_ok` may arrive one or more cycles after `data_addr_ok`, never in the same cycle.
- Back-to-back stores: with `data_data_ok` at cycle u and more stores pending, `data_req`=1 at u+1 carrying the new head.
- `drain_empty` rises the cycle after the last pop.

## Test plan
- Single store: retire at t=0 with head {addr 0x8000_1004, wstrb 1111, data 0xDEADBEEF}; `addr_ok` at t=3, `data_ok` at t=5 → `data_req` high t=2..3, `data_addr`=0x0000_1004, size 2; `sb_pop`=1 only at t=5; `pending` 1→0 at t=6; `drain_empty`=1 at t=6.
- Size mapping: strobes 0100 @0xA000_0002 → size 0, addr 0x0000_0002; 1100 @0x0040_0002 → size 1, addr 0x0040_0002; 0111 @0x8000_0013 → size 2, addr 0x0000_0010.
- Burst: 3 retires on t=0..2, with memory giving `addr_ok` immediately and `data_ok` one cycle later → exactly 3 requests in head order, 3 `sb_pop` pulses, no idle gap between a `data_ok` and the next `data_req`; `pending` returns to 0.
- Simultaneous events: `retire_store` and `sb_pop` in the same cycle with `pending`=2 → `pending` stays 2 and FSM goes WAIT→REQ.
- Gating: `pending`=1 while `sb_head_valid`=0 for 4 cycles → `data_req` stays 0; it rises 1 cycle after `sb_head_valid` rises.
- Reset mid-transaction: assert `resetn`=0 in WAIT → `data_req`/`sb_pop` drop immediately; a `data_data_ok` pulse after release produces no `sb_pop`; `drain_empty`=1.
